// File: rtl/ntt_bitrev_sequencer_pkg.sv
// ntt_bitrev_sequencer_pkg: default NTT widths and the index bit-reversal function shared by NTT blocks
package ntt_bitrev_sequencer_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_LOG_N  = 3;
    localparam int MAX_LOG_N  = 10;

    // Mirror the low w bits of i; bits above w come back as zero
    function automatic logic [MAX_LOG_N-1:0] bitrev(input logic [MAX_LOG_N-1:0] i, input int w);
        logic [MAX_LOG_N-1:0] r;
        r = '0;
        for (int b = 0; b < w; b++) r[b] = i[w-1-b];
        return r;
    endfunction

endpackage

// File: rtl/ntt_bitrev_sequencer_addr.sv
// ntt_bitrev_addr: combinational LOG_N-bit index mirror used on the read address
module ntt_bitrev_addr
    import ntt_bitrev_sequencer_pkg::*;
#(
    parameter int LOG_N = DEF_LOG_N
) (
    input  logic [LOG_N-1:0] idx,
    output logic [LOG_N-1:0] rev
);

    assign rev = LOG_N'(bitrev(MAX_LOG_N'(idx), LOG_N));

endmodule

// File: rtl/ntt_bitrev_sequencer.sv
// ntt_bitrev_sequencer: ping-pong buffer taking natural-order coefficients and draining each frame bit-reversed; BITREV_BYPASS_EN adds a per-frame natural-order bypass
module ntt_bitrev_sequencer
    import ntt_bitrev_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LOG_N  = DEF_LOG_N
) (
    input  logic              clk,
    input  logic              rst,
`ifdef BITREV_BYPASS_EN
    input  logic              bypass,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int N = 1 << LOG_N;
    localparam logic [LOG_N-1:0] LAST = '1;

    logic [DATA_W-1:0] bank0 [N];
    logic [DATA_W-1:0] bank1 [N];
    logic              wr_bank, rd_bank;
    logic [LOG_N-1:0]  wr_cnt, rd_cnt;
    logic [1:0]        full;
    logic              wr_acc, rd_acc;
    logic [LOG_N-1:0]  rev_addr, rd_addr;
    logic [DATA_W-1:0] rd_word;

    assign in_ready  = !rst && !full[wr_bank];
    assign wr_acc    = in_valid && in_ready;
    assign out_valid = full[rd_bank];
    assign rd_acc    = out_valid && out_ready;

    ntt_bitrev_addr #(.LOG_N(LOG_N)) u_addr (
        .idx (rd_cnt),
        .rev (rev_addr)
    );

`ifdef BITREV_BYPASS_EN
    logic [1:0] mode;
    assign rd_addr = mode[rd_bank] ? rd_cnt : rev_addr;
`else
    assign rd_addr = rev_addr;
`endif

    assign rd_word  = rd_bank ? bank1[rd_addr] : bank0[rd_addr];
    assign out_data = out_valid ? rd_word : '0;
    assign out_last = out_valid && rd_cnt == LAST;
    assign busy     = |full || wr_cnt != '0;

    // Coefficient storage; contents are don't-care until a frame is written
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            if (wr_bank) bank1[wr_cnt] <= in_data;
            else         bank0[wr_cnt] <= in_data;
        end
    end

    // Bank pointers, beat counters and full flags; write and read completions hit different banks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            full    <= 2'b00;
`ifdef BITREV_BYPASS_EN
            mode    <= 2'b00;
`endif
        end else begin
            if (wr_acc) begin
                wr_cnt <= wr_cnt + 1'b1;
`ifdef BITREV_BYPASS_EN
                if (wr_cnt == '0) mode[wr_bank] <= bypass;
`endif
                if (wr_cnt == LAST) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= !wr_bank;
                end
            end
            if (rd_acc) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_cnt == LAST) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= !rd_bank;
                end
            end
        end
    end

endmodule
